wire_pattern_gen: RTL
=====================

# wire_pattern_gen

Upstream stimulus stage for the 3-bit net demo block. It drives a programmable sequence of 3-bit patterns onto a net, with a valid/ready handshake so the downstream net consumer samples each value exactly once. The block supplies the constant, counting, walking-one and Gray sequences that the consumer stage checks.

## Interface
- `WIDTH`, 3: net width; the pattern tables are defined for 3.
- `HOLD_W`, 4: width of the inter-pattern gap counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `abort` in 1: synchronous cancel of the running sequence.
- `mode` in 2: 00 constant, 01 count-up, 10 walking-one, 11 Gray; captured at start.
- `hold` in HOLD_W: idle cycles between accepted patterns; captured at start.
- `num_pat` in 4: number of patterns to send; captured at start.
- `net_out` out WIDTH: current pattern.
- `net_valid` out 1: `net_out` is valid.
- `net_ready` in 1: consumer accepts.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the sequence completes.

## Operation
- **States.** IDLE, DRIVE, GAP, DONE.
- **IDLE.**
  - On `start`, capture `mode`, `hold` and `num_pat`, load the first pattern, and go to DRIVE.
  - If `num_pat`==0, go to DONE instead and make no transfer.
- **DRIVE.**
  - `net_valid`=1.
  - A transfer is the edge with `net_valid && net_ready`.
  - `net_out` stays stable until the transfer. The consumer may hold `net_ready` low indefinitely.
  - On transfer, decrement the remaining count.
  - If remaining reaches 0, go to DONE.
  - Else if `hold`==0, stay in DRIVE with the next pattern (back-to-back).
  - Else go to GAP with the counter loaded with `hold`.
- **GAP.**
  - `net_valid`=0 and `net_out` keeps its last value.
  - The counter decrements each cycle. When it reaches 1, go to DRIVE with the next pattern.
- **DONE.** `done`=1 for exactly one cycle, then IDLE.
- **Sequences.** All wrap modulo 8.
  - Constant: 100 every pattern.
  - Count-up: 000, 001, … 111, 000.
  - Walking-one: 001, 010, 100, 001.
  - Gray: 000, 001, 011, 010, 110, 111, 101, 100, 000.
- **Abort.** In DRIVE, GAP or DONE, go to IDLE on the next edge with `net_valid`=0 and no `done` pulse. Abort takes priority over a simultaneous transfer, which still counts as accepted by the consumer.
- **Ignored inputs.**
  - `start` while busy is ignored.
  - `start` and `abort` together in IDLE: `abort` wins and nothing starts.
- **Reset values.** `net_out`=000, `net_valid`=0, `busy`=0, `done`=0, state IDLE, counters 0.

## Timing
- `start` sampled at edge k gives `net_valid`=1 and `net_out`=first pattern after edge k (latency 1).
- With `hold`=h>0, the next `net_valid` rises h cycles after the transfer edge.
- With `hold`=0, one pattern per cycle while `net_ready`=1.
- `done` is high in the cycle after the last transfer edge. `busy` falls on the following edge.
- `rst_n` low at any time, including mid-transfer, forces the reset values immediately without waiting for `clk`. Deassertion is synchronised externally.

## Configuration
- **`WIRE_PATGEN_PARITY_EN` defined.**
  - Adds output `net_par` (1 bit) = XOR of `net_out`, registered with it.
  - Reset value 0.
  - Valid under the same `net_valid` qualification as `net_out`.
- **Not defined.** The `net_par` port and its logic are absent. All other behaviour is identical.

## Structure
- **Package `wire_patgen_pkg`.**
  - Mode encoding constants.
  - State enum.
  - The 8-entry Gray table.
  - Reset pattern 000 and constant pattern 100.
- **Sub-module `wire_pat_step`.** Combinational: (`mode`, current pattern) → next pattern. The top level owns the FSM, counters and handshake.

## Test plan
- Reset mid-DRIVE with `net_valid`=1 → outputs go to 000/0/0/0 immediately; restarting with count-up resumes from 000.
- Count-up: `num_pat`=10, `hold`=0, `net_ready`=1 → 000…111, 000, 001 on consecutive cycles, `done` pulse in cycle 11, `busy` low in cycle 12.
- Gray: `num_pat`=4, `hold`=2, `net_ready`=1 → 000, 001, 011, 010, each valid for 1 cycle followed by a 2-cycle gap.
- Backpressure, walking-one: `net_ready` low 5 cycles then high → `net_out` stays 001 for 6 cycles, next pattern 010.
- `abort` asserted in GAP after 2 of 5 constant patterns → IDLE next cycle, no `done` pulse, `busy` low; `start` while busy is ignored.
- `num_pat`=0 → no `net_valid`, `done` 1 cycle after start; with `WIRE_PATGEN_PARITY_EN`, `net_par`=1 on every pattern in constant mode.

Source files
------------

// File: rtl/wire_pattern_gen_pkg.sv
// Shared types and pattern tables for the 3-bit net stimulus generator.
// Optional parity output is enabled by defining WIRE_PATGEN_PARITY_EN.
package wire_patgen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_WALK  = 2'b10,
        MODE_GRAY  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int PAT_W = 3;
    typedef logic [PAT_W-1:0] pat_t;

    localparam pat_t PAT_RESET = 3'b000;
    localparam pat_t PAT_CONST = 3'b100;

    // Entry [0] is the first Gray code; the sequence wraps from [7] back to [0].
    localparam logic [7:0][2:0] GRAY_TABLE = {
        3'b100, 3'b101, 3'b111, 3'b110,
        3'b010, 3'b011, 3'b001, 3'b000
    };

    function automatic pat_t first_pat(input mode_e m);
        case (m)
            MODE_CONST: first_pat = PAT_CONST;
            MODE_WALK:  first_pat = 3'b001;
            default:    first_pat = PAT_RESET;
        endcase
    endfunction

endpackage

// File: rtl/wire_pattern_gen_if.sv
// Net handshake bundle between the pattern generator and the net consumer.
// Carries net_par only when WIRE_PATGEN_PARITY_EN is defined.
interface wire_pattern_gen_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] net_out;
    logic             net_valid;
    logic             net_ready;
`ifdef WIRE_PATGEN_PARITY_EN
    logic             net_par;

    modport master (output net_out, output net_valid, output net_par, input net_ready);
    modport slave  (input net_out, input net_valid, input net_par, output net_ready);
`else
    modport master (output net_out, output net_valid, input net_ready);
    modport slave  (input net_out, input net_valid, output net_ready);
`endif
endinterface

// File: rtl/wire_pattern_gen_step.sv
// Combinational next-pattern function: (mode, current pattern) -> next pattern.
module wire_pat_step
    import wire_patgen_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            MODE_CONST: nxt = PAT_CONST;
            MODE_COUNT: nxt = cur + WIDTH'(1);
            MODE_WALK:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_GRAY: begin
                // Locate the current code in the table and emit its successor.
                for (int unsigned i = 0; i < 8; i++) begin
                    if (GRAY_TABLE[i[2:0]] == cur)
                        nxt = GRAY_TABLE[i[2:0] + 3'd1];
                end
            end
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/wire_pattern_gen.sv
// Programmable 3-bit pattern source with valid/ready handshake and inter-pattern gap.
// Define WIRE_PATGEN_PARITY_EN to add the registered net_par output.
module wire_pattern_gen
    import wire_patgen_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [HOLD_W-1:0] hold,
    input  logic [3:0]        num_pat,
    output logic              busy,
    output logic              done,
    wire_pattern_gen_if.master net
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] gap_q, gap_d;
    logic [3:0]        rem_q, rem_d;
    logic [WIDTH-1:0]  pat_q, pat_d;
    logic [WIDTH-1:0]  pat_next;
    logic              xfer;

    wire_pat_step #(.WIDTH(WIDTH)) u_step (
        .mode (mode_q),
        .cur  (pat_q),
        .nxt  (pat_next)
    );

    assign xfer = (state_q == ST_DRIVE) && net.net_ready;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        rem_d   = rem_q;
        pat_d   = pat_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mode_d = mode_e'(mode);
                    hold_d = hold;
                    rem_d  = num_pat;
                    if (num_pat == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                        pat_d   = first_pat(mode_e'(mode));
                    end
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = ST_DONE;
                    end else if (hold_q == '0) begin
                        pat_d = pat_next;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = hold_q;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gap_q == HOLD_W'(1)) begin
                    state_d = ST_DRIVE;
                    gap_d   = '0;
                    pat_d   = pat_next;
                end else begin
                    gap_d = gap_q - HOLD_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CONST;
            hold_q  <= '0;
            gap_q   <= '0;
            rem_q   <= '0;
            pat_q   <= PAT_RESET;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            pat_q   <= pat_d;
        end
    end

`ifdef WIRE_PATGEN_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= ^pat_d;
    end

    assign net.net_par = par_q;
`endif

    assign net.net_out   = pat_q;
    assign net.net_valid = (state_q == ST_DRIVE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

endmodule
